// File: rtl/gray_step_decoder_pkg.sv
// Shared types and constants for the Gray step decoder.
// Holds the FSM state encoding and the default widths.
package gray_step_decoder_pkg;

  localparam int GRAY_W_DEF     = 4;
  localparam int POS_W_DEF      = 16;
  localparam int ERR_W_DEF      = 8;
  localparam int STABLE_CNT_DEF = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

endpackage

// File: rtl/gray_step_decoder_sync.sv
// Two-flop synchronizer for the asynchronous Gray bus.
// Gray coding keeps a multi-bit capture coherent when only one bit moves at a time.
module gray_step_decoder_sync #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/gray_step_decoder.sv
// Receives a remote Gray counter, decodes it and classifies each change as +1, -1 or illegal.
// Drives a wrapping position accumulator and a saturating error counter.
module gray_step_decoder
  import gray_step_decoder_pkg::*;
#(
  parameter int GRAY_W     = GRAY_W_DEF,
  parameter int POS_W      = POS_W_DEF,
  parameter int ERR_W      = ERR_W_DEF,
  parameter int STABLE_CNT = STABLE_CNT_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [GRAY_W-1:0] i_gray,
  input  logic              i_clr_err,
  output logic [GRAY_W-1:0] o_bin,
  output logic              o_inc,
  output logic              o_dec,
  output logic              o_err,
  output logic              o_locked,
  output logic [POS_W-1:0]  o_pos,
  output logic [ERR_W-1:0]  o_err_cnt
);

  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [GRAY_W-1:0] sync_gray;
  logic [GRAY_W-1:0] dec_bin;
  logic [GRAY_W-1:0] step;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  stable_cnt, stable_cnt_nxt;
  logic              inc_nxt, dec_nxt, err_nxt;
  logic [POS_W-1:0]  pos_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;

  gray_step_decoder_sync #(.W(GRAY_W)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .d       (i_gray),
    .q       (sync_gray)
  );

  always_comb begin
    dec_bin = '0;
    dec_bin[GRAY_W-1] = sync_gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      dec_bin[i] = dec_bin[i+1] ^ sync_gray[i];
    end
  end

  assign step = dec_bin - o_bin;

  // INIT and FAULT behave identically: wait for STABLE_CNT unchanged samples before tracking.
  always_comb begin
    state_nxt      = state;
    stable_cnt_nxt = stable_cnt;
    inc_nxt        = 1'b0;
    dec_nxt        = 1'b0;
    err_nxt        = 1'b0;
    case (state)
      ST_TRACK: begin
        if (step == GRAY_W'(1)) begin
          inc_nxt = 1'b1;
        end else if (step == '1) begin
          dec_nxt = 1'b1;
        end else if (step != '0) begin
          err_nxt        = 1'b1;
          state_nxt      = ST_FAULT;
          stable_cnt_nxt = '0;
        end
      end
      default: begin
        if (step != '0) begin
          stable_cnt_nxt = '0;
        end else if (stable_cnt == CNT_LAST) begin
          state_nxt      = ST_TRACK;
          stable_cnt_nxt = '0;
        end else begin
          stable_cnt_nxt = stable_cnt + CNT_W'(1);
        end
      end
    endcase
  end

  // A clear wins over a same-cycle error so software sees a clean zero afterwards.
  always_comb begin
    pos_nxt = o_pos;
    if (inc_nxt) begin
      pos_nxt = o_pos + POS_W'(1);
    end else if (dec_nxt) begin
      pos_nxt = o_pos - POS_W'(1);
    end
    err_cnt_nxt = o_err_cnt;
    if (i_clr_err) begin
      err_cnt_nxt = '0;
    end else if (err_nxt && (o_err_cnt != '1)) begin
      err_cnt_nxt = o_err_cnt + ERR_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_INIT;
      stable_cnt <= '0;
      o_bin      <= '0;
      o_inc      <= 1'b0;
      o_dec      <= 1'b0;
      o_err      <= 1'b0;
      o_pos      <= '0;
      o_err_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= stable_cnt_nxt;
      o_bin      <= dec_bin;
      o_inc      <= inc_nxt;
      o_dec      <= dec_nxt;
      o_err      <= err_nxt;
      o_pos      <= pos_nxt;
      o_err_cnt  <= err_cnt_nxt;
    end
  end

  assign o_locked = (state == ST_TRACK);

endmodule

// File: tb/tb_gray_step_decoder.sv
// Directed self-checking bench for gray_step_decoder with default parameters.
module tb_gray_step_decoder;

  logic        i_clk;
  logic        i_rst_n;
  logic [3:0]  i_gray;
  logic        i_clr_err;
  logic [3:0]  o_bin;
  logic        o_inc;
  logic        o_dec;
  logic        o_err;
  logic        o_locked;
  logic [15:0] o_pos;
  logic [7:0]  o_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int incs, decs, errs, multi, locked_seen;

  gray_step_decoder dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_gray    (i_gray),
    .i_clr_err (i_clr_err),
    .o_bin     (o_bin),
    .o_inc     (o_inc),
    .o_dec     (o_dec),
    .o_err     (o_err),
    .o_locked  (o_locked),
    .o_pos     (o_pos),
    .o_err_cnt (o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic clear_counts();
    incs = 0; decs = 0; errs = 0; multi = 0; locked_seen = 0;
  endtask

  task automatic sample();
    @(posedge i_clk);
    #1;
    if (o_inc) incs++;
    if (o_dec) decs++;
    if (o_err) errs++;
    if ((int'(o_inc) + int'(o_dec) + int'(o_err)) > 1) multi++;
    if (o_locked) locked_seen++;
  endtask

  task automatic step_and_wait(input logic [3:0] g, input int n);
    @(negedge i_clk);
    i_gray = g;
    for (int i = 0; i < n; i++) sample();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_gray = 4'b0000; i_clr_err = 1'b0;
    #3;
    n_checks++;
    if ({o_bin, o_inc, o_dec, o_err, o_locked, o_pos, o_err_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got bin=%0d pos=%0d errcnt=%0d locked=%0b expected all zero",
               o_bin, o_pos, o_err_cnt, o_locked);
    end
    @(negedge i_clk); @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 3; i++) sample();
    n_checks++;
    if (o_locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL lock_early: got %0b expected 0", o_locked);
    end
    sample();
    n_checks++;
    if (o_locked !== 1'b1) begin
      n_fail++; $display("[TB] FAIL lock_time: got %0b expected 1", o_locked);
    end
    n_checks++;
    if (o_bin !== 4'd0 || o_pos !== 16'd0 || (incs + decs + errs) != 0) begin
      n_fail++;
      $display("[TB] FAIL lock_state: got bin=%0d pos=%0d pulses=%0d expected 0/0/0", o_bin, o_pos, incs + decs + errs);
    end
  endtask

  task automatic test_inc();
    clear_counts();
    @(negedge i_clk);
    i_gray = 4'b0001;
    sample(); sample();
    n_checks++;
    if (o_bin !== 4'd0 || o_inc !== 1'b0) begin
      n_fail++; $display("[TB] FAIL inc_latency_early: got bin=%0d inc=%0b expected 0/0", o_bin, o_inc);
    end
    sample();
    n_checks++;
    if (o_bin !== 4'd1 || o_inc !== 1'b1) begin
      n_fail++; $display("[TB] FAIL inc_latency: got bin=%0d inc=%0b expected 1/1", o_bin, o_inc);
    end
    for (int i = 0; i < 5; i++) sample();
    step_and_wait(4'b0011, 8);
    step_and_wait(4'b0010, 8);
    n_checks++;
    if (incs != 3 || decs != 0 || errs != 0) begin
      n_fail++; $display("[TB] FAIL inc_pulses: got inc=%0d dec=%0d err=%0d expected 3/0/0", incs, decs, errs);
    end
    n_checks++;
    if (o_bin !== 4'd3 || o_pos !== 16'd3) begin
      n_fail++; $display("[TB] FAIL inc_pos: got bin=%0d pos=%0d expected 3/3", o_bin, o_pos);
    end
  endtask

  task automatic test_wrap();
    clear_counts();
    step_and_wait(4'b0011, 8);
    step_and_wait(4'b0001, 8);
    step_and_wait(4'b0000, 8);
    n_checks++;
    if (decs != 3 || o_pos !== 16'd0 || o_bin !== 4'd0) begin
      n_fail++; $display("[TB] FAIL dec_steps: got dec=%0d pos=%0d bin=%0d expected 3/0/0", decs, o_pos, o_bin);
    end
    clear_counts();
    step_and_wait(4'b1000, 8);
    n_checks++;
    if (decs != 1 || incs != 0 || o_pos !== 16'hFFFF || o_bin !== 4'd15) begin
      n_fail++; $display("[TB] FAIL wrap_down: got dec=%0d pos=%0h bin=%0d expected 1/ffff/15", decs, o_pos, o_bin);
    end
    clear_counts();
    step_and_wait(4'b0000, 8);
    n_checks++;
    if (incs != 1 || decs != 0 || o_pos !== 16'd0 || o_bin !== 4'd0) begin
      n_fail++; $display("[TB] FAIL wrap_up: got inc=%0d pos=%0h bin=%0d expected 1/0/0", incs, o_pos, o_bin);
    end
  endtask

  task automatic test_error();
    clear_counts();
    @(negedge i_clk);
    i_gray = 4'b0011;
    sample(); sample(); sample();
    n_checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 8'd1 || o_locked !== 1'b0 || o_bin !== 4'd2 || o_pos !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL err_detect: got err=%0b cnt=%0d locked=%0b bin=%0d pos=%0d expected 1/1/0/2/0",
               o_err, o_err_cnt, o_locked, o_bin, o_pos);
    end
    sample(); sample(); sample();
    n_checks++;
    if (o_err !== 1'b0 || o_locked !== 1'b0) begin
      n_fail++; $display("[TB] FAIL err_hold: got err=%0b locked=%0b expected 0/0", o_err, o_locked);
    end
    sample();
    n_checks++;
    if (o_locked !== 1'b1 || errs != 1 || incs != 0 || decs != 0) begin
      n_fail++; $display("[TB] FAIL err_relock: got locked=%0b errs=%0d expected 1/1", o_locked, errs);
    end
    clear_counts();
    @(negedge i_clk);
    i_gray = 4'b0000;
    sample(); sample(); sample();
    locked_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge i_clk);
      i_gray = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      sample();
    end
    n_checks++;
    if (locked_seen != 0 || incs != 0 || decs != 0 || errs != 1 || o_err_cnt !== 8'd2) begin
      n_fail++;
      $display("[TB] FAIL fault_toggle: got locked_cycles=%0d inc=%0d dec=%0d err=%0d cnt=%0d expected 0/0/0/1/2",
               locked_seen, incs, decs, errs, o_err_cnt);
    end
    for (int i = 0; i < 10; i++) sample();
    n_checks++;
    if (o_locked !== 1'b1 || o_bin !== 4'd0 || o_err_cnt !== 8'd2 || o_pos !== 16'd0) begin
      n_fail++;
      $display("[TB] FAIL fault_relock: got locked=%0b bin=%0d cnt=%0d pos=%0d expected 1/0/2/0",
               o_locked, o_bin, o_err_cnt, o_pos);
    end
  endtask

  task automatic test_saturate();
    clear_counts();
    for (int i = 0; i < 260; i++) begin
      step_and_wait((i % 2 == 0) ? 4'b0011 : 4'b0000, 8);
    end
    n_checks++;
    if (errs != 260 || multi != 0 || o_err_cnt !== 8'd255) begin
      n_fail++; $display("[TB] FAIL err_saturate: got errs=%0d cnt=%0d expected 260/255", errs, o_err_cnt);
    end
    @(negedge i_clk);
    i_gray = 4'b0011;
    sample(); sample();
    @(negedge i_clk);
    i_clr_err = 1'b1;
    sample();
    n_checks++;
    if (o_err !== 1'b1 || o_err_cnt !== 8'd0) begin
      n_fail++; $display("[TB] FAIL clr_priority: got err=%0b cnt=%0d expected 1/0", o_err, o_err_cnt);
    end
    @(negedge i_clk);
    i_clr_err = 1'b0;
    for (int i = 0; i < 6; i++) sample();
    step_and_wait(4'b0000, 8);
    n_checks++;
    if (o_err_cnt !== 8'd1 || o_locked !== 1'b1) begin
      n_fail++; $display("[TB] FAIL clr_then_err: got cnt=%0d locked=%0b expected 1/1", o_err_cnt, o_locked);
    end
  endtask

  task automatic test_back_to_back_reset();
    clear_counts();
    step_and_wait(4'b0001, 8);
    step_and_wait(4'b0011, 8);
    step_and_wait(4'b0010, 8);
    step_and_wait(4'b0110, 8);
    step_and_wait(4'b0111, 8);
    n_checks++;
    if (incs != 5 || o_pos !== 16'd5 || o_bin !== 4'd5) begin
      n_fail++; $display("[TB] FAIL pre_reset_pos: got inc=%0d pos=%0d bin=%0d expected 5/5/5", incs, o_pos, o_bin);
    end
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({o_bin, o_inc, o_dec, o_err, o_locked, o_pos, o_err_cnt} !== '0) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got bin=%0d pos=%0d cnt=%0d locked=%0b expected all zero",
               o_bin, o_pos, o_err_cnt, o_locked);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 6; i++) sample();
    n_checks++;
    if (o_locked !== 1'b0 || o_bin !== 4'd5) begin
      n_fail++; $display("[TB] FAIL relock_early: got locked=%0b bin=%0d expected 0/5", o_locked, o_bin);
    end
    sample();
    n_checks++;
    if (o_locked !== 1'b1 || o_pos !== 16'd0 || (incs + decs + errs) != 0) begin
      n_fail++;
      $display("[TB] FAIL relock_after_reset: got locked=%0b pos=%0d pulses=%0d expected 1/0/0",
               o_locked, o_pos, incs + decs + errs);
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_error();
    test_saturate();
    test_back_to_back_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
